satd_blk_ctrl: RTL
==================

// Module: satd_blk_ctrl
// PURPOSE
//  Initiator/sequencer for the 4x4 Hadamard SATD unit (had).
//  Fetches ref/cur pixel rows of a BLK_W x BLK_H block from pixel memory, splits it into 4x4 sub-blocks.
//  Drives the had input rows plus the en and export_data_had strobes, collects had_4x4 and accumulates block SATD.
//  Sits between the affine ME pixel buffers and the cost comparator.
// PARAMETERS
//  BLK_W   16  block width in pixels, multiple of 4, range 4..128
//  BLK_H   16  block height in pixels, multiple of 4, range 4..128
//  ACC_W   24  SATD accumulator width, saturating
// PORTS
//  clk            in   1     clock
//  rst_n          in   1     asynchronous reset, active-low
//  start          in   1     start one block; sampled only in IDLE
//  busy           out  1     high from the cycle after start is accepted through the done cycle
//  done           out  1     one-cycle pulse; satd is final in this cycle
//  satd           out  ACC_W accumulated block SATD; holds until the next start
//  mem_rd_en      out  1     row read request
//  mem_rd_x       out  8     4-pixel column group index (pixel x = 4*mem_rd_x)
//  mem_rd_y       out  8     pixel row index
//  mem_rd_ref     in   32    ref row data, 1-cycle fixed latency; [31:24] = leftmost pixel
//  mem_rd_cur     in   32    cur row data, same timing as mem_rd_ref
//  had_en         out  1     had en strobe
//  had_export     out  1     had export_data_had strobe
//  had_ref_blk1..4 out 32    sub-block rows 0..3 (ref), driven from internal row registers
//  had_cur_blk1..4 out 32    sub-block rows 0..3 (cur)
//  had_4x4        in   16    had result
// BEHAVIOUR
//  Reset values: busy=0, done=0, satd=0, mem_rd_en=0, mem_rd_x=0, mem_rd_y=0, had_en=0, had_export=0, row regs=0.
//  FSM states: IDLE, FETCH, WAIT, ISSUE, DRAIN, DONE.
//  - IDLE: start=1 -> clear satd, sub-block index = (0,0), go to FETCH.
//  - FETCH (4 cycles, k=0..3): mem_rd_en=1, mem_rd_y = 4*sby+k, mem_rd_x = sbx.
//    Data returned the next cycle is latched into row reg k (ref and cur).
//  - WAIT (1 cycle): latch row 3.
//  - ISSUE (1 cycle): had_en=1.
//    If more sub-blocks remain, advance the index raster-wise (x fastest) and go to FETCH; else go to DRAIN.
//  - Sub-block period is 6 cycles, so at most one result is ever in flight.
//  Result pipeline (3-bit shift reg seeded by ISSUE):
//  - had_export=1 exactly 2 cycles after had_en.
//  - had_4x4 is added to satd at the end of the cycle 3 cycles after had_en.
//  - DRAIN lasts until the last add completes, then go to DONE.
//  - DONE: done=1 for one cycle, then IDLE.
//  Latency: start high in IDLE at cycle 0; N = (BLK_W/4)*(BLK_H/4).
//  - Sub-block i ISSUE at cycle 6(i+1); done and final satd at cycle 6N+4.
//  - 16x16: 100 cycles. 4x4: 10 cycles.
//  Arithmetic: satd = sat(satd + zero-extended had_4x4), clamped at 2^ACC_W-1. No wrap ever.
//  had_en stays 0 outside ISSUE; had treats en=0 as zeroing its stage, so idle cycles are harmless.
//  Boundary conditions:
//  - start while busy: ignored.
//  - start held high through DONE: re-accepted only after returning to IDLE.
//  - Reset mid-operation: all state returns to reset values immediately; a pending export/add is discarded.
//  - Rows and columns past BLK_W/BLK_H are never addressed.
// TESTING
//  1. ref==cur (all 0x80), 16x16, start at cycle 0 -> satd=0, done high at cycle 100 only, busy cycles 1..100.
//  2. ref=cur+1 every pixel -> each had_4x4=2, satd=32; had_en at cycles 6,12,..,96.
//  3. Raster check: 8x8 block -> mem_rd_(x,y) sequence (0,0..3),(1,0..3),(0,4..7),(1,4..7); done at cycle 28.
//  4. ACC_W=8, ref=255, cur=0, 16x16 -> satd saturates at 255, no wrap.
//  5. rst_n low at cycle 40 of a 16x16 run -> all outputs reset at once; new start later gives the correct satd with no stale add.
//  6. start pulsed at cycles 0 and 50 (busy) -> only one done, at cycle 100; start at cycle 101 begins a new block.

Source files
------------

// File: rtl/satd_blk_ctrl.sv
// satd_blk_ctrl: sequencer for the 4x4 Hadamard SATD unit.
// Walks a BLK_W x BLK_H block in 4x4 sub-blocks in raster order (x fastest).
// For each sub-block it fetches four ref/cur rows, presents them to the had
// unit with a single en strobe, and folds the returned had_4x4 into a
// saturating block SATD accumulator.
module satd_blk_ctrl #(
    parameter int BLK_W = 16,
    parameter int BLK_H = 16,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] satd,
    output logic             mem_rd_en,
    output logic [7:0]       mem_rd_x,
    output logic [7:0]       mem_rd_y,
    input  logic [31:0]      mem_rd_ref,
    input  logic [31:0]      mem_rd_cur,
    output logic             had_en,
    output logic             had_export,
    output logic [31:0]      had_ref_blk1,
    output logic [31:0]      had_ref_blk2,
    output logic [31:0]      had_ref_blk3,
    output logic [31:0]      had_ref_blk4,
    output logic [31:0]      had_cur_blk1,
    output logic [31:0]      had_cur_blk2,
    output logic [31:0]      had_cur_blk3,
    output logic [31:0]      had_cur_blk4,
    input  logic [15:0]      had_4x4
);

    // Last sub-block column/row index of the block.
    localparam int SBX_LAST = BLK_W / 4 - 1;
    localparam int SBY_LAST = BLK_H / 4 - 1;

    // The adder is wide enough for either operand plus a carry, so an
    // overflow of the accumulator is always visible before clamping.
    localparam int SUM_W = ((ACC_W > 16) ? ACC_W : 16) + 1;
    localparam logic [SUM_W-1:0] SAT_MAX = (SUM_W'(1) << ACC_W) - SUM_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       k;
    logic [7:0]       sbx;
    logic [7:0]       sby;
    logic [31:0]      ref_row [4];
    logic [31:0]      cur_row [4];
    logic [2:0]       res_pipe;
    logic             last_sb;
    logic             row_we;
    logic [1:0]       row_idx;
    logic [SUM_W-1:0] sum;
    logic [ACC_W-1:0] satd_sat;

    assign had_ref_blk1 = ref_row[0];
    assign had_ref_blk2 = ref_row[1];
    assign had_ref_blk3 = ref_row[2];
    assign had_ref_blk4 = ref_row[3];
    assign had_cur_blk1 = cur_row[0];
    assign had_cur_blk2 = cur_row[1];
    assign had_cur_blk3 = cur_row[2];
    assign had_cur_blk4 = cur_row[3];

    // Row-capture decode (data lags the request by one cycle) and saturating add.
    always_comb begin
        last_sb  = (sbx == 8'(SBX_LAST)) && (sby == 8'(SBY_LAST));
        row_we   = ((state == FETCH) && (k != 2'd0)) || (state == WAIT);
        row_idx  = (state == WAIT) ? 2'd3 : (k - 2'd1);
        sum      = SUM_W'(satd) + SUM_W'(had_4x4);
        satd_sat = (sum > SAT_MAX) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        mem_rd_en = 1'b0;
        mem_rd_x  = 8'd0;
        mem_rd_y  = 8'd0;
        had_en    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                mem_rd_en = 1'b1;
                mem_rd_x  = sbx;
                mem_rd_y  = {sby[5:0], 2'b00} + {6'd0, k};
                if (k == 2'd3) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                state_nxt = ISSUE;
            end
            ISSUE: begin
                had_en    = 1'b1;
                state_nxt = last_sb ? DRAIN : FETCH;
            end
            DRAIN: begin
                if (res_pipe[2]) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Row-within-fetch counter and raster sub-block index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k   <= 2'd0;
            sbx <= 8'd0;
            sby <= 8'd0;
        end else begin
            k <= (state == FETCH) ? (k + 2'd1) : 2'd0;
            if ((state == IDLE) && start) begin
                sbx <= 8'd0;
                sby <= 8'd0;
            end else if ((state == ISSUE) && !last_sb) begin
                if (sbx == 8'(SBX_LAST)) begin
                    sbx <= 8'd0;
                    sby <= sby + 8'd1;
                end else begin
                    sbx <= sbx + 8'd1;
                end
            end
        end
    end

    // Capture returned ref/cur rows into the row registers feeding had.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                ref_row[i] <= 32'd0;
                cur_row[i] <= 32'd0;
            end
        end else if (row_we) begin
            ref_row[row_idx] <= mem_rd_ref;
            cur_row[row_idx] <= mem_rd_cur;
        end
    end

    // Result timing: export two cycles after en, accumulate in the third.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_pipe <= 3'd0;
            satd     <= '0;
        end else begin
            res_pipe <= {res_pipe[1:0], (state == ISSUE)};
            if ((state == IDLE) && start) begin
                satd <= '0;
            end else if (res_pipe[2]) begin
                satd <= satd_sat;
            end
        end
    end

    assign had_export = res_pipe[1];

endmodule
